// File: rtl/ula_pkg.sv
// Shared types for the ula arbiter slice.
// Opcode and FSM state enums plus the datapath width.
package ula_pkg;

  localparam int W = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_EQ  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ula_arb_if.sv
// Request/response bundle between two requesters,
// the arbiter and the result consumer.
interface ula_arb_if;
  import ula_pkg::*;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [2:0]   req0_op;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [2:0]   req1_op;

  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [W-1:0] resp_r;
  logic         resp_zero;

  logic         busy;
  logic [7:0]   done_cnt;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_r, resp_zero,
    input  busy, done_cnt
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_r, resp_zero,
    output busy, done_cnt
  );

endinterface

// File: rtl/ula.sv
// Purely combinational 4-bit ula: add/sub/and/or/xor/eq.
// Unknown opcodes yield r=0 (zero flag set).
module ula
  import ula_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] r,
  output logic         zero
);

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_EQ:   r = {{(W-1){1'b0}}, a == b};
      default: r = '0;
    endcase
    zero = (r == '0);
  end

endmodule

// File: rtl/ula_arb.sv
// Two-requester front end for a single shared ula,
// one operation in flight: IDLE -> EXEC -> RESP.
module ula_arb
  import ula_pkg::*;
#(
  parameter bit PRIO_FIXED = 1'b0
) (
  input logic     clk,
  input logic     rst_n,
  ula_arb_if.slave bus
);

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [2:0]   op_q, op_d;
  logic         id_q, id_d;
  logic         last_q, last_d;
  logic [W-1:0] r_q, r_d;
  logic         zero_q, zero_d;
  logic [7:0]   cnt_q, cnt_d;

  logic         idle;
  logic         gnt0;
  logic         gnt1;
  logic [W-1:0] ula_r;
  logic         ula_zero;

  ula u_ula (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .r    (ula_r),
    .zero (ula_zero)
  );

  // ready is gated by rst_n so it stays low while reset is held
  always_comb begin
    idle = rst_n && (state_q == IDLE);
    if (PRIO_FIXED)
      gnt1 = bus.req1_valid && !bus.req0_valid;
    else
      gnt1 = bus.req1_valid &&
             (!bus.req0_valid || !last_q);
    gnt0 = bus.req0_valid && !gnt1;
  end

  assign bus.req0_ready = idle && gnt0;
  assign bus.req1_ready = idle && gnt1;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    id_d    = id_q;
    last_d  = last_q;
    r_d     = r_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          a_d     = gnt1 ? bus.req1_a  : bus.req0_a;
          b_d     = gnt1 ? bus.req1_b  : bus.req0_b;
          op_d    = gnt1 ? bus.req1_op : bus.req0_op;
          id_d    = gnt1;
          last_d  = gnt1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        r_d     = ula_r;
        zero_d  = ula_zero;
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      r_q     <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      last_q  <= last_d;
      r_q     <= r_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_r     = r_q;
  assign bus.resp_zero  = zero_q;
  assign bus.resp_id    = id_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done_cnt   = cnt_q;

endmodule

// File: tb/tb_ula_arb.sv
// Bench for ula_arb: round-robin and fixed-priority
// instances driven side by side, checked against a model.
module tb_ula_arb;
  import ula_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_arb_if if0();
  ula_arb_if if1();

  ula_arb #(.PRIO_FIXED(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  ula_arb #(.PRIO_FIXED(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic       v0 = 0, v1 = 0, rr = 0;
  logic [3:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [2:0] op0 = 0, op1 = 0;

  assign if0.req0_valid = v0;
  assign if0.req0_a     = a0;
  assign if0.req0_b     = b0;
  assign if0.req0_op    = op0;
  assign if0.req1_valid = v1;
  assign if0.req1_a     = a1;
  assign if0.req1_b     = b1;
  assign if0.req1_op    = op1;
  assign if0.resp_ready = rr;
  assign if1.req0_valid = v0;
  assign if1.req0_a     = a0;
  assign if1.req0_b     = b0;
  assign if1.req0_op    = op0;
  assign if1.req1_valid = v1;
  assign if1.req1_a     = a1;
  assign if1.req1_b     = b1;
  assign if1.req1_op    = op1;
  assign if1.resp_ready = rr;

  int checks = 0;
  int passed = 0;

  function automatic logic [3:0] ref_r(
    input logic [2:0] op, input int a, input int b);
    int x;
    case (op)
      3'd0:    x = (a + b) % 16;
      3'd1:    x = (a - b + 16) % 16;
      3'd2:    x = a & b;
      3'd3:    x = a | b;
      3'd4:    x = a ^ b;
      3'd5:    x = (a == b) ? 1 : 0;
      default: x = 0;
    endcase
    return 4'(x);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; v0 = 0; v1 = 0; rr = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    logic [17:0] s0, s1;
    @(negedge clk);
    rst_n = 0; v0 = 1; v1 = 1; rr = 1;
    a0 = 1; b0 = 1; op0 = 0; a1 = 2; b1 = 2; op1 = 0;
    #1;
    s0 = {if0.req0_ready, if0.req1_ready, if0.resp_valid,
          if0.resp_zero, if0.resp_id, if0.busy,
          if0.resp_r, if0.done_cnt};
    s1 = {if1.req0_ready, if1.req1_ready, if1.resp_valid,
          if1.resp_zero, if1.resp_id, if1.busy,
          if1.resp_r, if1.done_cnt};
    checks++;
    if (s0 !== 18'h0)
      $display("FAIL reset_rr: got %h want 0", s0);
    else passed++;
    checks++;
    if (s1 !== 18'h0)
      $display("FAIL reset_fix: got %h want 0", s1);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if ({if0.req0_ready, if0.req1_ready} !== 2'b10)
      $display("FAIL first_tie: got %b want 10",
               {if0.req0_ready, if0.req1_ready});
    else passed++;
    @(negedge clk);
    v0 = 0; v1 = 0;
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    v0 = 1; a0 = 3; b0 = 2; op0 = 3'b000; rr = 1;
    #1;
    checks++;
    if ({if0.req0_ready, if0.req1_ready} !== 2'b10)
      $display("FAIL basic_ready: got %b want 10",
               {if0.req0_ready, if0.req1_ready});
    else passed++;
    @(negedge clk);
    v0 = 0;
    #1;
    checks++;
    if ({if0.resp_valid, if0.busy} !== 2'b01)
      $display("FAIL basic_exec: got %b want 01",
               {if0.resp_valid, if0.busy});
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if ({if0.resp_valid, if0.resp_r, if0.resp_zero,
         if0.resp_id} !== {1'b1, 4'd5, 1'b0, 1'b0})
      $display("FAIL basic_resp: got v%b r%0d z%b id%b want v1 r5 z0 id0",
               if0.resp_valid, if0.resp_r, if0.resp_zero, if0.resp_id);
    else passed++;
    @(negedge clk);
    #1;
    checks++;
    if ({if0.resp_valid, if0.done_cnt} !== {1'b0, 8'd1})
      $display("FAIL basic_done: got v%b cnt%0d want v0 cnt1",
               if0.resp_valid, if0.done_cnt);
    else passed++;
  endtask

  task automatic test_alternate();
    int g0q[$];
    int fix0, fix1;
    int want_seq[4] = '{0, 1, 0, 1};
    fix0 = 0; fix1 = 0;
    do_reset();
    @(negedge clk);
    v0 = 1; a0 = 7; b0 = 5; op0 = 3'b001;
    v1 = 1; a1 = 7; b1 = 7; op1 = 3'b001;
    rr = 1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (if0.req0_ready) g0q.push_back(0);
      if (if0.req1_ready) g0q.push_back(1);
      if (if1.req0_ready) fix0++;
      if (if1.req1_ready) fix1++;
      if (if0.resp_valid && g0q.size() > 0) begin
        checks++;
        if ({if0.resp_id, if0.resp_r, if0.resp_zero} !==
            (g0q[$] == 1 ? {1'b1, 4'd0, 1'b1}
                         : {1'b0, 4'd2, 1'b0}))
          $display("FAIL alt_resp: got id%b r%0d z%b grant %0d",
                   if0.resp_id, if0.resp_r, if0.resp_zero, g0q[$]);
        else passed++;
      end
      @(negedge clk);
    end
    v0 = 0; v1 = 0;
    checks++;
    if (g0q.size() != 4)
      $display("FAIL alt_count: got %0d want 4", g0q.size());
    else passed++;
    for (int i = 0; i < 4 && i < g0q.size(); i++) begin
      checks++;
      if (g0q[i] != want_seq[i])
        $display("FAIL alt_seq%0d: got %0d want %0d",
                 i, g0q[i], want_seq[i]);
      else passed++;
    end
    checks++;
    if (fix1 != 0 || fix0 != 4)
      $display("FAIL fixed_prio: got g0=%0d g1=%0d want 4 0",
               fix0, fix1);
    else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    v0 = 1; a0 = 9; b0 = 4; op0 = 3'b100; rr = 0;
    #1;
    checks++;
    if (if0.req0_ready !== 1'b1)
      $display("FAIL stall_acc: got %b want 1", if0.req0_ready);
    else passed++;
    @(negedge clk);
    v0 = 0; v1 = 1; a1 = 1; b1 = 1; op1 = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({if0.resp_valid, if0.resp_r, if0.req0_ready,
           if0.req1_ready, if0.done_cnt} !==
          {1'b1, 4'd13, 1'b0, 1'b0, 8'd0})
        $display("FAIL stall_hold%0d: got v%b r%0d rdy%b%b cnt%0d want v1 r13 rdy00 cnt0",
                 i, if0.resp_valid, if0.resp_r, if0.req0_ready,
                 if0.req1_ready, if0.done_cnt);
      else passed++;
      @(negedge clk);
    end
    rr = 1;
    @(negedge clk);
    #1;
    checks++;
    if ({if0.resp_valid, if0.done_cnt, if0.req1_ready} !==
        {1'b0, 8'd1, 1'b1})
      $display("FAIL stall_rel: got v%b cnt%0d rdy1 %b want v0 cnt1 rdy1 1",
               if0.resp_valid, if0.done_cnt, if0.req1_ready);
    else passed++;
    @(negedge clk);
    v1 = 0;
  endtask

  task automatic test_reset_exec();
    logic [17:0] s0;
    do_reset();
    @(negedge clk);
    v0 = 1; a0 = 15; b0 = 1; op0 = 3'b000; rr = 1;
    @(negedge clk);
    v0 = 0;
    #1;
    checks++;
    if (if0.busy !== 1'b1)
      $display("FAIL rexec_busy: got %b want 1", if0.busy);
    else passed++;
    rst_n = 0;
    #1;
    s0 = {if0.req0_ready, if0.req1_ready, if0.resp_valid,
          if0.resp_zero, if0.resp_id, if0.busy,
          if0.resp_r, if0.done_cnt};
    checks++;
    if (s0 !== 18'h0)
      $display("FAIL rexec_rst: got %h want 0", s0);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({if0.resp_valid, if0.busy, if0.done_cnt} !== 10'd0)
        $display("FAIL rexec_after%0d: got v%b b%b cnt%0d want 0",
                 i, if0.resp_valid, if0.busy, if0.done_cnt);
      else passed++;
    end
  endtask

  task automatic test_random();
    int         ph[2];
    logic       last[2];
    int         cnt[2];
    logic [3:0] er[2];
    logic       ei[2];
    logic       rd0, rd1, rv, rz, rid, bz, e0, e1;
    logic [3:0] rres;
    logic [7:0] dc;
    for (int k = 0; k < 2; k++) begin
      ph[k] = 0; last[k] = 1; cnt[k] = 0;
      er[k] = 0; ei[k] = 0;
    end
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      v0  = ($urandom % 3) != 0;
      v1  = ($urandom % 3) != 0;
      a0  = 4'($urandom_range(15));
      b0  = 4'($urandom_range(15));
      a1  = 4'($urandom_range(15));
      b1  = 4'($urandom_range(15));
      op0 = 3'($urandom_range(7));
      op1 = 3'($urandom_range(7));
      rr  = ($urandom % 4) != 0;
      #1;
      for (int k = 0; k < 2; k++) begin
        rd0  = k == 0 ? if0.req0_ready : if1.req0_ready;
        rd1  = k == 0 ? if0.req1_ready : if1.req1_ready;
        rv   = k == 0 ? if0.resp_valid : if1.resp_valid;
        rres = k == 0 ? if0.resp_r     : if1.resp_r;
        rz   = k == 0 ? if0.resp_zero  : if1.resp_zero;
        rid  = k == 0 ? if0.resp_id    : if1.resp_id;
        bz   = k == 0 ? if0.busy       : if1.busy;
        dc   = k == 0 ? if0.done_cnt   : if1.done_cnt;
        e0 = 0; e1 = 0;
        if (ph[k] == 0) begin
          if (v0 && v1) e1 = (k == 0) && (last[k] == 0);
          else e1 = v1;
          e0 = v0 && !e1;
        end
        checks++;
        if ({rd0, rd1} !== {e0, e1})
          $display("FAIL rnd_grant k%0d c%0d: got %b%b want %b%b",
                   k, c, rd0, rd1, e0, e1);
        else passed++;
        checks++;
        if ({rv, bz, dc} !== {ph[k] == 2, ph[k] != 0, 8'(cnt[k])})
          $display("FAIL rnd_state k%0d c%0d: got v%b b%b cnt%0d want ph%0d cnt%0d",
                   k, c, rv, bz, dc, ph[k], cnt[k]);
        else passed++;
        if (ph[k] == 2) begin
          checks++;
          if ({rres, rz, rid} !== {er[k], er[k] == 4'd0, ei[k]})
            $display("FAIL rnd_resp k%0d c%0d: got r%0d z%b id%b want r%0d id%b",
                     k, c, rres, rz, rid, er[k], ei[k]);
          else passed++;
        end
        if (ph[k] == 0 && (e0 || e1)) begin
          er[k] = e1 ? ref_r(op1, a1, b1) : ref_r(op0, a0, b0);
          ei[k] = e1;
          last[k] = e1;
          ph[k] = 1;
        end else if (ph[k] == 1) begin
          ph[k] = 2;
        end else if (ph[k] == 2 && rr) begin
          ph[k] = 0;
          cnt[k]++;
        end
      end
    end
    @(negedge clk);
    v0 = 0; v1 = 0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_q[$];
    logic [3:0] want;
    logic [3:0] fixed_r[3] = '{4'b1000, 4'b1110, 4'b0110};
    logic [2:0] sel[3] = '{3'b010, 3'b011, 3'b100};
    int n_acc, n_done;
    n_acc = 0; n_done = 0;
    do_reset();
    rr = 1; a0 = 4'b1100; b0 = 4'b1010; v1 = 0;
    for (int c = 0; c < 1000 && n_done < 256; c++) begin
      @(negedge clk);
      v0 = 1;
      op0 = sel[n_acc % 3];
      #1;
      if (if0.req0_ready) begin
        exp_q.push_back(ref_r(op0, a0, b0));
        n_acc++;
      end
      if (if0.resp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL wrap_q: response with none outstanding");
        end else begin
          want = exp_q.pop_front();
          if ({if0.resp_r, if0.done_cnt} !==
              {want, 8'(n_done)})
            $display("FAIL wrap_resp%0d: got r%0d cnt%0d want r%0d cnt%0d",
                     n_done, if0.resp_r, if0.done_cnt, want, n_done);
          else passed++;
        end
        if (n_done < 3) begin
          checks++;
          if (if0.resp_r !== fixed_r[n_done])
            $display("FAIL logic_op%0d: got %b want %b",
                     n_done, if0.resp_r, fixed_r[n_done]);
          else passed++;
        end
        n_done++;
      end
    end
    @(negedge clk);
    v0 = 0;
    #1;
    checks++;
    if (n_done != 256)
      $display("FAIL wrap_timeout: got %0d want 256", n_done);
    else passed++;
    checks++;
    if (if0.done_cnt !== 8'd0)
      $display("FAIL wrap_cnt: got %0d want 0", if0.done_cnt);
    else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_stall();
    test_reset_exec();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
